// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Contents: controller state enum, destination-tracking slot struct,
// ID/EXE NOP encoding.
package pipe_ctrl_pkg;

    // Slot address storage width; register addresses up to this width are
    // zero-extended into a slot.
    localparam int unsigned SLOT_ADDR_W = 8;

    typedef enum logic [0:0] {
        ST_DRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // One in-flight destination: valid flag plus register address.
    typedef struct packed {
        logic                   v;
        logic [SLOT_ADDR_W-1:0] addr;
    } slot_t;

    // Bubble encoding loaded into ID/EXE.
    localparam logic [2:0] NOP_ALUOP = 3'b000;
    localparam logic       NOP_WEN   = 1'b0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage / controller interface.
// master: datapath side (drives ID decode fields and flush, receives controls)
// slave:  hazard controller (receives ID decode fields, drives controls)
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              id_valid;
    logic [ADDR_W-1:0] id_raddr1;
    logic [ADDR_W-1:0] id_raddr2;
    logic              id_use1;
    logic              id_use2;
    logic              id_wen;
    logic [ADDR_W-1:0] id_waddr;
    logic              flush;
    logic              pc_hold;
    logic              ifid_hold;
    logic              idex_bubble;
    logic              hazard;
    logic              busy_flush;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_raddr1, id_raddr2, id_use1, id_use2,
               id_wen, id_waddr, flush,
        input  pc_hold, ifid_hold, idex_bubble, hazard, busy_flush,
               stall_count
    );

    modport slave (
        input  id_valid, id_raddr1, id_raddr2, id_use1, id_use2,
               id_wen, id_waddr, flush,
        output pc_hold, ifid_hold, idex_bubble, hazard, busy_flush,
               stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_slot_pipe.sv
// hazard_slot_pipe: 3-deep shift register of destination slots (EXE -> MEM -> WB).
// Ports: clk; clear (synchronous, empties every slot); exe_in (slot entering EXE);
//        exe/mem/wb (registered slot contents per stage).
module hazard_slot_pipe
    import pipe_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  clear,
    input  slot_t exe_in,
    output slot_t exe,
    output slot_t mem,
    output slot_t wb
);

    // Shift one stage per cycle; clear drops everything in flight.
    always_ff @(posedge clk) begin
        if (clear) begin
            exe <= '0;
            mem <= '0;
            wb  <= '0;
        end else begin
            exe <= exe_in;
            mem <= exe;
            wb  <= mem;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: RAW interlock and post-reset drain sequencer for a
// 5-stage pipeline without forwarding.
// Ports: clk; rst (synchronous, active-high);
//        bus (slave): ID decode fields + flush in; pc_hold, ifid_hold,
//        idex_bubble, hazard, busy_flush, stall_count out.
// hazard and the hold/bubble controls are combinational from registered
// state plus the current ID fields, so a stall takes effect in the same cycle.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W       = 5,
    parameter bit          WB_BYPASS    = 1'b0,
    parameter bit          ZERO_REG     = 1'b1,
    parameter int unsigned FLUSH_CYCLES = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int unsigned DRAIN_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(FLUSH_CYCLES - 1);

    localparam logic [0:0] S_DRAIN = ST_DRAIN;
    localparam logic [0:0] S_RUN   = ST_RUN;

    logic [0:0]         state;
    logic [0:0]         state_nxt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DRAIN_W-1:0] drain_nxt;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   stall_nxt;

    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [ADDR_W-1:0] waddr;

    slot_t slot_in;
    slot_t slot_exe;
    slot_t slot_mem;
    slot_t slot_wb;

    logic match1;
    logic match2;
    logic hazard_c;
    logic pc_hold_c;
    logic ifid_hold_c;
    logic idex_bubble_c;
    logic busy_flush_c;

    assign raddr1 = bus.id_raddr1;
    assign raddr2 = bus.id_raddr2;
    assign waddr  = bus.id_waddr;

    // True when any in-flight slot will still write the given source register.
    function automatic logic src_pending(input logic use_s,
                                         input logic [ADDR_W-1:0] raddr,
                                         input slot_t exe_s,
                                         input slot_t mem_s,
                                         input slot_t wb_s);
        logic [SLOT_ADDR_W-1:0] a;
        logic                   hit;
        a   = SLOT_ADDR_W'(raddr);
        hit = (exe_s.v && exe_s.addr == a) ||
              (mem_s.v && mem_s.addr == a) ||
              (wb_s.v  && wb_s.addr  == a && !WB_BYPASS);
        return use_s && (!ZERO_REG || raddr != '0) && hit;
    endfunction

    assign match1   = src_pending(bus.id_use1, raddr1, slot_exe, slot_mem, slot_wb);
    assign match2   = src_pending(bus.id_use2, raddr2, slot_exe, slot_mem, slot_wb);
    assign hazard_c = (state == S_RUN) && bus.id_valid && !bus.flush && (match1 || match2);

    // A stalled, flushed or drain-time instruction never reaches EXE as a writer.
    always_comb begin
        slot_in      = '0;
        slot_in.v    = bus.id_valid && bus.id_wen && !bus.flush && !hazard_c &&
                       (state == S_RUN);
        slot_in.addr = SLOT_ADDR_W'(waddr);
    end

    hazard_slot_pipe u_slots (
        .clk    (clk),
        .clear  (rst),
        .exe_in (slot_in),
        .exe    (slot_exe),
        .mem    (slot_mem),
        .wb     (slot_wb)
    );

    // State, drain counter and stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_DRAIN;
            drain_cnt <= DRAIN_LOAD;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            stall_cnt <= stall_nxt;
        end
    end

    // Next state and pipeline control outputs.
    always_comb begin
        state_nxt     = state;
        drain_nxt     = drain_cnt;
        pc_hold_c     = 1'b0;
        ifid_hold_c   = 1'b0;
        idex_bubble_c = 1'b0;
        busy_flush_c  = 1'b0;

        case (state)
            S_DRAIN: begin
                pc_hold_c     = 1'b1;
                idex_bubble_c = 1'b1;
                busy_flush_c  = 1'b1;
                if (drain_cnt == '0) begin
                    state_nxt = S_RUN;
                end else begin
                    drain_nxt = drain_cnt - DRAIN_W'(1);
                end
            end
            S_RUN: begin
                if (hazard_c) begin
                    pc_hold_c     = 1'b1;
                    ifid_hold_c   = 1'b1;
                    idex_bubble_c = 1'b1;
                end
            end
            default: begin
                state_nxt = S_DRAIN;
                drain_nxt = DRAIN_LOAD;
            end
        endcase

        // A redirect lets fetch proceed and kills the ID instruction.
        if (bus.flush) begin
            pc_hold_c     = 1'b0;
            ifid_hold_c   = 1'b0;
            idex_bubble_c = 1'b1;
        end
    end

    // Saturating stall-cycle counter.
    always_comb begin
        stall_nxt = stall_cnt;
        if (hazard_c && stall_cnt != '1) begin
            stall_nxt = stall_cnt + CNT_W'(1);
        end
    end

    assign bus.pc_hold     = pc_hold_c;
    assign bus.ifid_hold   = ifid_hold_c;
    assign bus.idex_bubble = idex_bubble_c;
    assign bus.hazard      = hazard_c;
    assign bus.busy_flush  = busy_flush_c;
    assign bus.stall_count = stall_cnt;

endmodule
